// File: rtl/encounter_director_pkg.sv
// rtl/encounter_director_pkg.sv - shared state codes, LFSR constants and screen origin for encounter_director
package encounter_director_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HIT  = 2'd2,
    ST_BAD  = 2'd3
  } state_e;

  // Seed doubles as the recovery value if the register is ever found at zero.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Taps 16,14,13,11 expressed for a right-shifting register (bits 0,2,3,5).
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  // The frame tick fires when the raster reaches this pixel.
  localparam logic [11:0] ORIGIN_COL = 12'd0;
  localparam logic [10:0] ORIGIN_ROW = 11'd0;

  // One Fibonacci step: parity of the tapped bits shifts in at the top.
  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    logic fb;
    fb = ^(cur & LFSR_TAPS);
    return {fb, cur[15:1]};
  endfunction

endpackage

// File: rtl/encounter_director_if.sv
// rtl/encounter_director_if.sv - raster, collision and encounter control signals shared with the sprite blocks
interface encounter_director_if #(
  parameter int N_ENC = 3
) ();

  logic [11:0]      display_col;
  logic [10:0]      display_row;
  logic             visible;
  logic             player_visible;
  logic [N_ENC-1:0] enc_visible;
  logic [N_ENC-1:0] spawn_key;
  logic             hit;

  // Video side: drives raster position and sprite coverage, receives control.
  modport master (
    output display_col, display_row, visible, player_visible, enc_visible,
    input  spawn_key, hit
  );

  // Director side.
  modport slave (
    input  display_col, display_row, visible, player_visible, enc_visible,
    output spawn_key, hit
  );

endinterface

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - button synchroniser with optional debounce (START_DEBOUNCE_EN) and rising-edge pulse
module key_conditioner #(
  parameter int DB_BITS = 18
) (
  input  logic clock,
  input  logic reset_n,
  input  logic key_raw,
  output logic key_rise
);

  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;
  logic       level;

`ifdef START_DEBOUNCE_EN
  logic               db_level_q, db_level_d;
  logic [DB_BITS-1:0] db_cnt_q, db_cnt_d;

  // Level flips only after the synchronised input has disagreed with it for 2^DB_BITS samples in a row.
  always_comb begin
    db_level_d = db_level_q;
    db_cnt_d   = '0;
    if (sync_q[1] != db_level_q) begin
      if (db_cnt_q == {DB_BITS{1'b1}}) begin
        db_level_d = sync_q[1];
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      db_level_q <= 1'b0;
      db_cnt_q   <= '0;
    end else begin
      db_level_q <= db_level_d;
      db_cnt_q   <= db_cnt_d;
    end
  end

  assign level = db_level_q;
`else
  assign level = sync_q[1];
`endif

  // Shift the raw key through the synchroniser and remember the last conditioned level.
  always_comb begin
    sync_d = {sync_q[0], key_raw};
    prev_d = level;
  end

  // Synchroniser and edge-detect registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign key_rise = level & ~prev_q;

endmodule

// File: rtl/encounter_director.sv
// rtl/encounter_director.sv - run/hit FSM, LFSR spawn scheduler and survival score (START_DEBOUNCE_EN adds start debounce)
module encounter_director
  import encounter_director_pkg::*;
#(
  parameter int         N_ENC     = 3,
  parameter int         MIN_GAP   = 40,
  parameter logic [7:0] GAP_MASK  = 8'h3F,
  parameter int         SCORE_DIV = 6,
  parameter int         DB_BITS   = 18
) (
  input  logic                  clock,
  input  logic                  reset_n,
  encounter_director_if.slave   vid,
  input  logic                  start_key,
  output logic [15:0]           score,
  output logic [1:0]            state_o
);

  localparam logic [8:0] GAP_INIT = 9'(MIN_GAP);
  localparam logic [7:0] DIV_LAST = 8'(SCORE_DIV - 1);

  state_e           state_q, state_d;
  logic [N_ENC-1:0] spawn_q, spawn_d;
  logic             hit_q, hit_d;
  logic [15:0]      score_q, score_d;
  logic             coll_q, coll_d;
  logic [8:0]       gap_q, gap_d;
  logic [7:0]       div_q, div_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic             origin_q, origin_d;

  logic             at_origin;
  logic             frame_tick;
  logic             start_edge;
  logic             coll_now;
  logic             frame_collided;
  logic [8:0]       gap_reload;
  logic [N_ENC-1:0] spawn_vec;
  int               spawn_idx;

  key_conditioner #(
    .DB_BITS (DB_BITS)
  ) u_start_key (
    .clock    (clock),
    .reset_n  (reset_n),
    .key_raw  (start_key),
    .key_rise (start_edge)
  );

  // Frame tick, collision sampling and the candidate spawn for this frame.
  always_comb begin
    at_origin      = (vid.display_col == ORIGIN_COL) && (vid.display_row == ORIGIN_ROW);
    frame_tick     = at_origin & ~origin_q;
    coll_now       = vid.visible & vid.player_visible & (|vid.enc_visible);
    frame_collided = coll_q | coll_now;
    gap_reload     = GAP_INIT + {1'b0, lfsr_q[7:0] & GAP_MASK};
    spawn_idx      = int'(lfsr_q[1:0]) % N_ENC;
    spawn_vec      = '0;
    for (int i = 0; i < N_ENC; i++) begin
      spawn_vec[i] = (i == spawn_idx);
    end
  end

  // Next-state logic for the FSM, scheduler, score and LFSR.
  always_comb begin
    state_d  = state_q;
    spawn_d  = spawn_q;
    score_d  = score_q;
    coll_d   = coll_q;
    gap_d    = gap_q;
    div_d    = div_q;
    lfsr_d   = lfsr_q;
    origin_d = at_origin;

    if (lfsr_q == 16'h0000) begin
      lfsr_d = LFSR_SEED;
    end else if (frame_tick) begin
      lfsr_d = lfsr_step(lfsr_q);
    end

    case (state_q)
      ST_IDLE: begin
        spawn_d = '0;
        coll_d  = 1'b0;
        if (start_edge) begin
          state_d = ST_RUN;
          score_d = 16'd0;
          gap_d   = GAP_INIT;
          div_d   = 8'd0;
        end
      end
      ST_RUN: begin
        if (frame_tick) begin
          coll_d  = 1'b0;
          spawn_d = '0;
          if (frame_collided) begin
            // A collision wins over any spawn due on the same tick.
            state_d = ST_HIT;
          end else begin
            if (gap_q <= 9'd1) begin
              spawn_d = spawn_vec;
              gap_d   = gap_reload;
            end else begin
              gap_d = gap_q - 9'd1;
            end
            if (div_q >= DIV_LAST) begin
              div_d = 8'd0;
              if (score_q != 16'hFFFF) begin
                score_d = score_q + 16'd1;
              end
            end else begin
              div_d = div_q + 8'd1;
            end
          end
        end else begin
          coll_d = frame_collided;
        end
      end
      ST_HIT: begin
        spawn_d = '0;
        coll_d  = 1'b0;
        if (start_edge) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        spawn_d = '0;
        coll_d  = 1'b0;
      end
    endcase

    hit_d = (state_d == ST_HIT);
  end

  // All director state, reset asynchronously.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      spawn_q  <= '0;
      hit_q    <= 1'b0;
      score_q  <= 16'd0;
      coll_q   <= 1'b0;
      gap_q    <= GAP_INIT;
      div_q    <= 8'd0;
      lfsr_q   <= LFSR_SEED;
      origin_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      spawn_q  <= spawn_d;
      hit_q    <= hit_d;
      score_q  <= score_d;
      coll_q   <= coll_d;
      gap_q    <= gap_d;
      div_q    <= div_d;
      lfsr_q   <= lfsr_d;
      origin_q <= origin_d;
    end
  end

  assign vid.spawn_key = spawn_q;
  assign vid.hit       = hit_q;
  assign score         = score_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_encounter_director.sv
// tb/tb_encounter_director.sv - randomized frame-level bench for encounter_director against a per-frame game model
module tb_encounter_director;

  localparam int FW = 8;
  localparam int FH = 4;
  localparam int FP = FW * FH;

  logic        clock;
  logic        reset_n;
  logic        start_key;
  logic [15:0] score;
  logic [1:0]  state_o;

  encounter_director_if #(.N_ENC(3)) vid ();

  encounter_director #(
    .N_ENC     (3),
    .MIN_GAP   (40),
    .GAP_MASK  (8'h3F),
    .SCORE_DIV (6),
    .DB_BITS   (18)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .vid       (vid),
    .start_key (start_key),
    .score     (score),
    .state_o   (state_o)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Game model: advanced once per frame boundary and on start presses / collisions.
  int          m_state;   // 0 idle, 1 run, 2 hit
  int          m_score;
  int          m_ticks;   // frame ticks left until the next spawn
  int          m_frames;  // scored frames since start
  bit          m_coll;
  logic [2:0]  m_spawn;
  logic [15:0] m_lfsr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    logic [15:0] b;
    b = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 16'h0001;
    return (l >> 1) | (b << 15);
  endfunction

  task automatic model_reset();
    m_state  = 0;
    m_score  = 0;
    m_ticks  = 40;
    m_frames = 0;
    m_coll   = 0;
    m_spawn  = 3'b000;
    m_lfsr   = 16'hACE1;
  endtask

  task automatic model_tick(input bit coll_now);
    logic [15:0] cur;
    cur    = m_lfsr;
    m_lfsr = lfsr_next(cur);
    if (m_state == 1) begin
      m_spawn = 3'b000;
      if (m_coll || coll_now) begin
        m_state = 2;
        m_coll  = 0;
      end else begin
        m_ticks--;
        if (m_ticks == 0) begin
          m_spawn = 3'b001 << ((cur % 4) % 3);
          m_ticks = 40 + (cur & 16'h003F);
        end
        m_frames++;
        if ((m_frames % 6) == 0 && m_score < 65535) m_score++;
      end
    end else begin
      m_spawn = 3'b000;
    end
  endtask

  task automatic model_start();
    if (m_state == 0) begin
      m_state  = 1;
      m_score  = 0;
      m_ticks  = 40;
      m_frames = 0;
      m_coll   = 0;
    end else if (m_state == 2) begin
      m_state = 0;
    end
  endtask

  task automatic check_outputs(input string where);
    check({where, "_state"}, 32'(state_o), 32'(m_state));
    check({where, "_hit"}, 32'(vid.hit), 32'(m_state == 2));
    check({where, "_spawn"}, 32'(vid.spawn_key), 32'(m_spawn));
    check({where, "_score"}, 32'(score), 32'(m_score));
  endtask

  // One raster frame. coll_pix selects the pixel that carries the given coverage pattern;
  // every other pixel is random coverage that never overlaps all three.
  task automatic run_frame(input bit press, input int coll_pix,
                           input bit cvis, input bit cpv, input logic [2:0] cenc);
    bit full;
    full = cvis && cpv && (cenc != 3'b000);
    for (int p = 0; p < FP; p++) begin
      @(negedge clock);
      if (p == 1) check_outputs("tick");
      if (p == FP - 1) check_outputs("eof");
      vid.display_col = 12'(p % FW);
      vid.display_row = 11'(p / FW);
      if (p == coll_pix) begin
        vid.visible        = cvis;
        vid.player_visible = cpv;
        vid.enc_visible    = cenc;
      end else begin
        vid.visible        = 1'($urandom);
        vid.player_visible = 1'($urandom);
        vid.enc_visible    = 3'($urandom);
        if (vid.visible && vid.enc_visible != 3'b000) vid.player_visible = 1'b0;
      end
      start_key = press && (p >= 8) && (p <= 10);
      if (p == 0) begin
        model_tick(coll_pix == 0 && full);
      end else if (p == coll_pix && full && m_state == 1) begin
        m_coll = 1;
      end
      if (p == 8 && press) model_start();
    end
  endtask

  task automatic quiet_frame();
    run_frame(1'b0, -1, 1'b0, 1'b0, 3'b000);
  endtask

  task automatic press_frame();
    run_frame(1'b1, -1, 1'b0, 1'b0, 3'b000);
  endtask

  initial begin
    int budget;
    clock              = 1'b0;
    reset_n            = 1'b0;
    start_key          = 1'b0;
    vid.display_col    = 12'd1;
    vid.display_row    = 11'd0;
    vid.visible        = 1'b0;
    vid.player_visible = 1'b0;
    vid.enc_visible    = 3'b000;
    model_reset();

    // Reset state.
    repeat (3) @(negedge clock);
    check_outputs("reset");
    reset_n = 1'b1;

    // Start, then 41 collision-free frames: first spawn at the 40th tick, score 6 at the 36th.
    press_frame();
    for (int f = 1; f <= 41; f++) begin
      quiet_frame();
      if (m_frames == 36) check("score_36", 32'(score), 32'd6);
      if (m_frames == 40) check("spawn40_onehot", 32'($countones(vid.spawn_key)), 32'd1);
      if (m_frames == 41) check("spawn41_clear", 32'(vid.spawn_key), 32'd0);
    end

    // Asynchronous reset mid-RUN, observed before any clock edge.
    @(negedge clock);
    check("pre_reset_state", 32'(state_o), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_reset");
    @(negedge clock);
    vid.display_col = 12'd1;
    vid.display_row = 11'd0;
    @(negedge clock);
    reset_n = 1'b1;

    // Mid-frame collision on encounter 1 leads to HIT at the next tick.
    press_frame();
    repeat (3) quiet_frame();
    run_frame(1'b0, 20, 1'b1, 1'b1, 3'b010);
    quiet_frame();
    check("hit_after_mid_coll", 32'(vid.hit), 32'd1);
    quiet_frame();

    // Start in HIT returns to IDLE with the score held; again starts a fresh run.
    press_frame();
    check("hit_to_idle", 32'(state_o), 32'd0);
    press_frame();
    check("idle_to_run", 32'(state_o), 32'd1);

    // Collision on the exact tick that would spawn: HIT, no spawn.
    budget = 200;
    while (m_ticks != 1 && budget > 0) begin
      quiet_frame();
      budget--;
    end
    check("spawn_wait_budget", 32'(budget > 0), 32'd1);
    run_frame(1'b0, 0, 1'b1, 1'b1, 3'b100);
    check("tick_coll_state", 32'(state_o), 32'd2);
    check("tick_coll_no_spawn", 32'(vid.spawn_key), 32'd0);

    // Overlaps masked by visible=0 or player_visible=0 never hit.
    press_frame();
    press_frame();
    for (int f = 0; f < 10; f++) begin
      if (f % 2 == 0) run_frame(1'b0, 20, 1'b0, 1'b1, 3'b010);
      else            run_frame(1'b0, 20, 1'b1, 1'b0, 3'b111);
    end
    check("masked_overlap_run", 32'(state_o), 32'd1);

    // Randomized play.
    for (int f = 0; f < 80; f++) begin
      int r;
      r = int'($urandom_range(0, 15));
      if (r == 0)      run_frame(1'b0, 0, 1'b1, 1'b1, 3'(($urandom % 7) + 1));
      else if (r < 3)  run_frame(1'b0, int'($urandom_range(12, 30)), 1'b1, 1'b1, 3'(($urandom % 7) + 1));
      else if (r < 6)  run_frame(1'b1, -1, 1'b0, 1'b0, 3'b000);
      else if (r == 6) run_frame(1'b1, int'($urandom_range(12, 30)), 1'b1, 1'b1, 3'b001);
      else             quiet_frame();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/encounter_director.md
Name: encounter_director

Overview:
- Game-side counterpart of the encounter sprite blocks.
- Consumes each encounter's `encN_visible` and the player sprite's visible flag; drives the `spawn_key` and `hit` inputs that the encounter blocks sample.
- Contains the run/hit state machine, a pseudo-random spawn scheduler and a survival score counter.
- Sits in the top level beside the pixel compositor, on the same clock as the VGA timing.

Parameters:
- N_ENC, 3: number of encounter blocks driven (1..4).
- MIN_GAP, 40: minimum frames between spawns.
- GAP_MASK, 8'h3F: mask applied to LFSR bits and added to MIN_GAP.
- SCORE_DIV, 6: frames per score increment.
- DB_BITS, 18: debounce counter width (used only with the optional feature).

Ports:
- clock  in  1  system/pixel clock
- reset_n  in  1  asynchronous, active-low reset
- display_col  in  12  current pixel column
- display_row  in  11  current pixel row
- visible  in  1  active display area
- player_visible  in  1  player sprite opaque at current pixel
- enc_visible  in  N_ENC  per-encounter opaque flag (`encN_visible`)
- start_key  in  1  raw start button, active-high
- spawn_key  out  N_ENC  per-encounter spawn request, level
- hit  out  1  freeze request to all encounters
- score  out  16  survival score, binary, saturating
- state_o  out  2  current FSM state, for the HUD

Behaviour:
- Reset (reset_n low, async):
  - state = IDLE; spawn_key = 0; hit = 0; score = 0.
  - collision flag = 0; gap counter = MIN_GAP; score divider = 0; LFSR = 16'hACE1.
- Frame tick:
  - frame_tick is a one-cycle pulse on the first clock where display_col==0 && display_row==0.
  - Detected as a rising edge of that condition against a registered copy of it.
- Start edge: start_edge is the rising edge of the synchronised start_key.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every frame_tick in every state. Never reaches zero; if it somehow does, force it to 16'hACE1.
- FSM states: IDLE=0, RUN=1, HIT=2. Code 3 is illegal and recovers to IDLE.
  - IDLE → RUN on start_edge. On that transition: score = 0, gap counter = MIN_GAP, collision flag cleared.
  - RUN → HIT on a frame_tick while the collision flag = 1.
  - HIT → IDLE on start_edge. hit clears on the same clock as the transition.
- Collision detection (RUN only):
  - Any cycle with visible && player_visible && |enc_visible sets a sticky collision flag.
  - The flag is evaluated and cleared on frame_tick.
  - A collision on the same cycle as frame_tick counts for the frame that is closing.
- hit:
  - Registered; 1 exactly while state==HIT.
  - Asserts the clock after the RUN→HIT frame_tick, i.e. one cycle after the tick. Encounters therefore move at most one more frame.
- Spawn scheduler (RUN only):
  - On each frame_tick the gap counter decrements.
  - When it reads 0 at a tick, spawn_key[idx] goes high with idx = lfsr[1:0] mod N_ENC.
  - spawn_key stays high until the next frame_tick, so it is stable at that tick's 0,0 cycle, which is when the encounters sample it.
  - The gap then reloads to MIN_GAP + (lfsr[7:0] & GAP_MASK).
  - Only one spawn bit is ever high at a time.
  - In IDLE and HIT, spawn_key = 0 and the gap is held.
  - If an encounter is still on screen it ignores the request; no retry is made.
- Score (RUN only):
  - The divider counts frame_ticks 0..SCORE_DIV-1. At wrap, score increments by 1.
  - Score saturates at 16'hFFFF.
  - In HIT, score is held for display. In IDLE, score holds until the next start.
- Simultaneous events:
  - A frame_tick that both triggers HIT and would spawn goes to HIT; the spawn is suppressed.
  - start_edge in RUN is ignored.
- Width rules: all counters are unsigned. The gap reload sum is 9-bit, with no overflow for the defaults.

Optional Feature:
- START_DEBOUNCE_EN defined:
  - start_key goes through a 2-flop synchroniser, then a DB_BITS-bit stable-time counter.
  - The debounced level changes only after 2^DB_BITS consecutive equal samples.
  - start_edge is derived from the debounced level.
- Not defined: 2-flop synchroniser only; start_edge is derived from its output.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE, ST_RUN, ST_HIT
  - the LFSR seed and tap constant
  - screen origin constants used for the frame_tick compare.
- One natural sub-module: `key_conditioner` (synchroniser + optional debounce + edge detect), which is reusable for other buttons.

Test Plan:
- Reset with reset_n low mid-RUN, asynchronously → all outputs 0 and state_o=0 within the same cycle, with no clock edge required.
- start_key pulse, then 41 frames with no collisions → state_o=1 and spawn_key has exactly one bit high for exactly one frame starting at tick 40. Score is 6 after 36 ticks, i.e. 36/SCORE_DIV.
- In RUN, one pixel with visible=player_visible=enc_visible[1]=1 mid-frame → hit rises one clock after the next frame_tick; state_o=2; spawn_key=0 thereafter.
- Collision asserted on the exact frame_tick cycle → HIT on that tick. A spawn due on that same tick is suppressed.
- Overlap with visible=0 or player_visible=0 → no HIT after 10 frames.
- In HIT, start_key pulse → hit=0 and state_o=0 the cycle after start_edge; the score value is held. A further start_key pulse → RUN with score reset to 0.
